note_sequencer_clk: RTL
=======================

Name: note_sequencer_clk

Overview:
- Parametrised successor to the fixed eight-output note clock bank.
- Produces one tone square wave whose note (C4..C5) and octave are chosen at run time, for a programmed number of beats, then reports completion.
- Contains a programmable-tempo beat prescaler.
- Sits between the keyboard/song-ROM sequencer (drives START and the note fields) and the speaker pin driver (TONE).

Parameters:
- BEAT_DIV, 54_400_000, CLK cycles per beat (544 ms quarter note at 100 MHz); must be >= 2.
- SCALE_SHIFT, 0, extra right shift applied to every half-period count; benches use 12.
- DUR_W, 4, width of the DUR field.
- GAP_CYCLES, 1_000_000, silence length after a note when NOTE_GAP_EN is defined; must be >= 1.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  request pulse; accepted only when BUSY=0.
- NOTE  in  3  0=C4 1=D 2=E 3=F 4=G 5=A 6=B 7=C5; sampled on accept.
- OCTAVE  in  2  octave up-shift 0..3; sampled on accept.
- DUR  in  DUR_W  note length in beats; 0 is treated as 1; sampled on accept.
- TONE  out  1  square-wave output; 0 whenever not playing.
- BUSY  out  1  high from accept until completion.
- DONE  out  1  one-cycle pulse at completion.
- BEAT_TICK  out  1  one-cycle pulse every BEAT_DIV cycles.

Behaviour:
- Reset: RESET is asynchronous, active-high; clock is CLK.
  - All outputs return to 0, state=IDLE, all counters 0.
  - RESET asserted mid-note aborts it: TONE=0 immediately, no DONE is generated.
- Half-period base table (100 MHz, round(1e8/2f)):
  - C4 191110, D 170266, E 151685, F 143172, G 127551, A 113636, B 101239, C5 95557.
  - hp = base >> (OCTAVE + SCALE_SHIFT), clamped to a minimum of 1.
  - Tone terminal count = hp-1; 18-bit tone counter.
- States:
  - IDLE: TONE=0, BUSY=0. START=1 at edge k latches NOTE/OCTAVE/DUR, sets BUSY=1, clears the tone counter and beat prescaler, loads remaining = max(DUR,1), then goes to PLAY.
  - PLAY: the tone counter increments each cycle; at terminal it goes to 0 and TONE toggles. The first TONE rise occurs hp cycles after accept; period = 2*hp.
  - End of PLAY: the prescaler counts 0..BEAT_DIV-1. At wrap, BEAT_TICK pulses and remaining decrements. The wrap with remaining==1 ends PLAY.
  - Completion without the gap: TONE<=0, BUSY<=0, DONE pulses for 1 cycle, state goes to IDLE. BUSY is high for exactly max(DUR,1)*BEAT_DIV cycles.
- Latched fields are immune to input changes during BUSY, so TONE never glitches mid-note.
- START while BUSY is ignored. START in the same cycle that DONE is asserted is accepted, since BUSY is already 0.
- Beat prescaler:
  - Free-running in IDLE, so BEAT_TICK keeps pulsing as a metronome.
  - Restarted at 0 on every accept, so note lengths are exact.
- BEAT_TICK is never asserted during RESET.

Optional Feature:
- Macro NOTE_GAP_EN.
- Defined: at the end of PLAY, TONE<=0 and state goes to GAP with BUSY still 1. GAP lasts GAP_CYCLES cycles, then DONE pulses, BUSY<=0 and state goes to IDLE. START during GAP is ignored.
- Undefined: there is no GAP state; completion happens exactly as described in Behaviour.

Test Plan:
- Reset: assert RESET asynchronously mid-cycle -> TONE, BUSY, DONE and BEAT_TICK all go to 0 before the next edge. Release, then wait BEAT_DIV=1000 cycles -> one BEAT_TICK pulse.
- SCALE_SHIFT=12, BEAT_DIV=1000; START with NOTE=5 (A), OCTAVE=0, DUR=2 -> hp=27, TONE toggles every 27 cycles, BUSY high for 2000 cycles, DONE is a single pulse, TONE=0 afterwards.
- SCALE_SHIFT=12; START with NOTE=0, OCTAVE=3 -> hp=191110>>15=5, TONE period 10 cycles. Changing NOTE/OCTAVE mid-note does not change the period.
- DUR=0 -> BUSY high for exactly 1000 cycles. A second START during BUSY is ignored. START on the DONE cycle is accepted and BUSY stays high.
- Assert RESET at cycle 500 of a DUR=3 note -> no DONE pulse. A new START after release plays a full note.
- NOTE_GAP_EN defined, GAP_CYCLES=50, DUR=1 -> TONE=0 after 1000 cycles, BUSY high for 1050 cycles, DONE pulses at the end of the gap.

Source files
------------

// File: rtl/note_sequencer_clk.sv
// Note sequencer clock: plays one square-wave tone (C4..C5, octave shifted) for a
// programmed number of beats, then pulses DONE. A free-running beat prescaler
// provides BEAT_TICK as a metronome and is restarted on every accepted note.
// Optional feature: define NOTE_GAP_EN to insert GAP_CYCLES of silence (BUSY held)
// after each note before DONE is reported.
module note_sequencer_clk #(
    parameter int unsigned BEAT_DIV    = 54_400_000,
    parameter int unsigned SCALE_SHIFT = 0,
    parameter int unsigned DUR_W       = 4,
    parameter int unsigned GAP_CYCLES  = 1_000_000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       NOTE,
    input  logic [1:0]       OCTAVE,
    input  logic [DUR_W-1:0] DUR,
    output logic             TONE,
    output logic             BUSY,
    output logic             DONE,
    output logic             BEAT_TICK
);

    localparam int unsigned PRE_W = $clog2(BEAT_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BEAT_DIV - 1);

    // Elaboration-time parameter sanity checks.
    if (BEAT_DIV < 2) begin : g_bad_beat_div
        $error("BEAT_DIV must be at least 2");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap_cycles
        $error("GAP_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StGap
    } state_e;

    state_e             state_q, state_d;
    logic [17:0]        tone_cnt_q, tone_cnt_d;
    logic [17:0]        tone_tc_q, tone_tc_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [DUR_W-1:0]   rem_q, rem_d;
    logic               tone_q, tone_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tick_q, tick_d;

`ifdef NOTE_GAP_EN
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
`endif

    logic [17:0]        base_hp;
    logic [17:0]        shifted_hp;
    logic [17:0]        accept_tc;
    logic               beat_wrap;

    // Half-period lookup for the requested note, scaled by octave and SCALE_SHIFT.
    always_comb begin
        case (NOTE)
            3'd0:    base_hp = 18'd191110;
            3'd1:    base_hp = 18'd170266;
            3'd2:    base_hp = 18'd151685;
            3'd3:    base_hp = 18'd143172;
            3'd4:    base_hp = 18'd127551;
            3'd5:    base_hp = 18'd113636;
            3'd6:    base_hp = 18'd101239;
            default: base_hp = 18'd95557;
        endcase
        shifted_hp = base_hp >> (32'(OCTAVE) + SCALE_SHIFT);
        // A half period of 0 is clamped to 1, i.e. terminal count 0.
        accept_tc  = (shifted_hp == '0) ? '0 : shifted_hp - 18'd1;
    end

    assign beat_wrap = (pre_q == PRE_LAST);

    // Next-state logic for the sequencer, tone generator and beat prescaler.
    always_comb begin
        state_d    = state_q;
        tone_cnt_d = tone_cnt_q;
        tone_tc_d  = tone_tc_q;
        rem_d      = rem_q;
        tone_d     = tone_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        // Prescaler free-runs in every state; an accept overrides it below.
        pre_d      = beat_wrap ? '0 : pre_q + PRE_W'(1);
        tick_d     = beat_wrap;
`ifdef NOTE_GAP_EN
        gap_cnt_d  = gap_cnt_q;
`endif

        case (state_q)
            StIdle: begin
                tone_d = 1'b0;
                busy_d = 1'b0;
                if (START) begin
                    // Latch the whole note so later input changes cannot glitch TONE.
                    tone_tc_d  = accept_tc;
                    tone_cnt_d = '0;
                    rem_d      = (DUR == '0) ? DUR_W'(1) : DUR;
                    pre_d      = '0;
                    tick_d     = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = StPlay;
                end
            end

            StPlay: begin
                if (tone_cnt_q == tone_tc_q) begin
                    tone_cnt_d = '0;
                    tone_d     = ~tone_q;
                end else begin
                    tone_cnt_d = tone_cnt_q + 18'd1;
                end
                if (beat_wrap) begin
                    if (rem_q == DUR_W'(1)) begin
                        tone_d = 1'b0;
`ifdef NOTE_GAP_EN
                        gap_cnt_d = '0;
                        state_d   = StGap;
`else
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
`endif
                    end else begin
                        rem_d = rem_q - DUR_W'(1);
                    end
                end
            end

`ifdef NOTE_GAP_EN
            StGap: begin
                tone_d = 1'b0;
                if (gap_cnt_q == GAP_LAST) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
`endif

            default: begin
                tone_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; asynchronous reset silences TONE at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= StIdle;
            tone_cnt_q <= '0;
            tone_tc_q  <= '0;
            pre_q      <= '0;
            rem_q      <= '0;
            tone_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tick_q     <= 1'b0;
`ifdef NOTE_GAP_EN
            gap_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tone_cnt_q <= tone_cnt_d;
            tone_tc_q  <= tone_tc_d;
            pre_q      <= pre_d;
            rem_q      <= rem_d;
            tone_q     <= tone_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tick_q     <= tick_d;
`ifdef NOTE_GAP_EN
            gap_cnt_q  <= gap_cnt_d;
`endif
        end
    end

    assign TONE      = tone_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign BEAT_TICK = tick_q;

endmodule
